// File: rtl/baud_gen_frac.sv
// -----------------------------------------------------------------------------
// baud_gen_frac
//
// Fractional baud-rate generator. Each oversample period lasts act_int clocks,
// stretched by one clock whenever the fractional accumulator carries, so the
// average period is act_int + act_frac / 2**FRAC_WIDTH. OVERSAMPLE oversample
// ticks make one bit period. A new divisor is staged in shadow registers and
// applied only at a bit boundary, or at once while the generator is disabled.
//
// Ports
//   clk           clock
//   rst           synchronous reset, active low
//   en            generator enable; low clears all timing state
//   div_int       integer divisor request (values below 2 are rejected)
//   div_frac      fractional divisor request
//   div_load      one-cycle pulse capturing div_int/div_frac into the shadow
//   os_tick       oversample tick, one clock wide
//   baud_tick     bit-boundary tick, one clock wide, coincident with os_tick
//   baud_clk      square wave at the bit rate, 50% duty in oversample units
//   load_pending  a captured divisor is waiting to be applied
//   cfg_err       sticky flag set by a rejected divisor request
// -----------------------------------------------------------------------------
module baud_gen_frac #(
  parameter int DIV_WIDTH    = 16,
  parameter int FRAC_WIDTH   = 4,
  parameter int OVERSAMPLE   = 16,
  parameter int DEFAULT_INT  = 10,
  parameter int DEFAULT_FRAC = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DIV_WIDTH-1:0]  div_int,
  input  logic [FRAC_WIDTH-1:0] div_frac,
  input  logic                  div_load,
  output logic                  os_tick,
  output logic                  baud_tick,
  output logic                  baud_clk,
  output logic                  load_pending,
  output logic                  cfg_err
);

  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int CNT_W = DIV_WIDTH + 1;

  localparam logic [DIV_WIDTH-1:0]  RST_INT  = DIV_WIDTH'(DEFAULT_INT);
  localparam logic [FRAC_WIDTH-1:0] RST_FRAC = FRAC_WIDTH'(DEFAULT_FRAC);
  localparam logic [OS_W-1:0]       OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [DIV_WIDTH-1:0]  MIN_INT  = DIV_WIDTH'(2);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [OS_W-1:0]       OS_ONE   = OS_W'(1);

  // Divisor state
  logic [DIV_WIDTH-1:0]  act_int_r;
  logic [FRAC_WIDTH-1:0] act_frac_r;
  logic [DIV_WIDTH-1:0]  shd_int_r;
  logic [FRAC_WIDTH-1:0] shd_frac_r;
  logic                  load_pending_r;
  logic                  cfg_err_r;

  // Timing state
  logic [FRAC_WIDTH-1:0] acc_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [OS_W-1:0]       os_cnt_r;
  logic                  started_r;
  logic                  os_tick_r;
  logic                  baud_tick_r;
  logic                  baud_clk_r;

  // Combinational helpers
  logic [FRAC_WIDTH:0]   frac_sum_s;
  logic [CNT_W-1:0]      period_s;
  logic                  period_end_s;
  logic                  wrap_s;
  logic                  load_ok_s;
  logic                  apply_s;
  logic [OS_W-1:0]       os_cnt_nxt_s;

  // Period length, end-of-period and bit-boundary detection, load decisions.
  always_comb begin
    frac_sum_s   = {1'b0, acc_r} + {1'b0, act_frac_r};
    // One extra bit so a maximal act_int plus the carry cannot wrap.
    period_s     = {1'b0, act_int_r} + {{DIV_WIDTH{1'b0}}, frac_sum_s[FRAC_WIDTH]};
    period_end_s = 1'b0;
    wrap_s       = 1'b0;
    os_cnt_nxt_s = os_cnt_r;
    load_ok_s    = div_load && (div_int >= MIN_INT);
    // started_r gates the first enabled edge, which only parks cnt at 0 so
    // the first tick lands a full period after enable.
    if (en && started_r && (cnt_r == (period_s - CNT_ONE))) begin
      period_end_s = 1'b1;
      wrap_s       = (os_cnt_r == OS_LAST);
      os_cnt_nxt_s = os_cnt_r + OS_ONE;
    end else begin
      period_end_s = 1'b0;
      wrap_s       = 1'b0;
      os_cnt_nxt_s = os_cnt_r;
    end
    // Staged divisors take effect at a bit boundary, or right away when idle.
    if (load_pending_r && (!en || wrap_s)) begin
      apply_s = 1'b1;
    end else begin
      apply_s = 1'b0;
    end
  end

  // Divisor shadow/active registers, pending flag and sticky error flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      act_int_r      <= RST_INT;
      act_frac_r     <= RST_FRAC;
      shd_int_r      <= RST_INT;
      shd_frac_r     <= RST_FRAC;
      load_pending_r <= 1'b0;
      cfg_err_r      <= 1'b0;
    end else begin
      // Old shadow moves to active before a coincident request overwrites it.
      if (apply_s) begin
        act_int_r  <= shd_int_r;
        act_frac_r <= shd_frac_r;
      end
      if (load_ok_s) begin
        shd_int_r      <= div_int;
        shd_frac_r     <= div_frac;
        load_pending_r <= 1'b1;
      end else if (apply_s) begin
        load_pending_r <= 1'b0;
      end
      if (load_ok_s) begin
        cfg_err_r <= 1'b0;
      end else if (div_load) begin
        cfg_err_r <= 1'b1;
      end
    end
  end

  // Cycle counter, fractional accumulator, oversample counter and ticks.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_r       <= {FRAC_WIDTH{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      os_cnt_r    <= {OS_W{1'b0}};
      started_r   <= 1'b0;
      os_tick_r   <= 1'b0;
      baud_tick_r <= 1'b0;
      baud_clk_r  <= 1'b0;
    end else if (!en) begin
      acc_r       <= {FRAC_WIDTH{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      os_cnt_r    <= {OS_W{1'b0}};
      started_r   <= 1'b0;
      os_tick_r   <= 1'b0;
      baud_tick_r <= 1'b0;
      baud_clk_r  <= 1'b0;
    end else if (!started_r) begin
      started_r   <= 1'b1;
      cnt_r       <= {CNT_W{1'b0}};
      os_tick_r   <= 1'b0;
      baud_tick_r <= 1'b0;
      baud_clk_r  <= ~os_cnt_nxt_s[OS_W-1];
    end else begin
      if (period_end_s) begin
        cnt_r       <= {CNT_W{1'b0}};
        // A divisor change restarts the fractional sequence from zero.
        acc_r       <= apply_s ? {FRAC_WIDTH{1'b0}} : frac_sum_s[FRAC_WIDTH-1:0];
        os_cnt_r    <= os_cnt_nxt_s;
        os_tick_r   <= 1'b1;
        baud_tick_r <= wrap_s;
      end else begin
        cnt_r       <= cnt_r + CNT_ONE;
        os_tick_r   <= 1'b0;
        baud_tick_r <= 1'b0;
      end
      // OVERSAMPLE is a power of two, so the MSB marks the second half.
      baud_clk_r <= ~os_cnt_nxt_s[OS_W-1];
    end
  end

  assign os_tick      = os_tick_r;
  assign baud_tick    = baud_tick_r;
  assign baud_clk     = baud_clk_r;
  assign load_pending = load_pending_r;
  assign cfg_err      = cfg_err_r;

endmodule

// File: tb/tb_baud_gen_frac.sv
`timescale 1ns/1ps
// Bench for baud_gen_frac: table-driven divisor runs checked by a scoreboard
// of expected tick intervals, plus hand-written load/reset/error sequences.
module tb_baud_gen_frac;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic        div_load;
  logic        os_tick;
  logic        baud_tick;
  logic        baud_clk;
  logic        load_pending;
  logic        cfg_err;

  baud_gen_frac dut (
    .clk(clk), .rst(rst), .en(en), .div_int(div_int), .div_frac(div_frac),
    .div_load(div_load), .os_tick(os_tick), .baud_tick(baud_tick),
    .baud_clk(baud_clk), .load_pending(load_pending), .cfg_err(cfg_err)
  );

  // 18.432 MHz
  initial clk = 1'b0;
  always #27.127 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int os_q[$];
  int baud_q[$];
  bit arm   = 1'b0;
  bit sb_on = 1'b0;
  int cyc   = 0;
  int last_os, last_baud, tcount;

  typedef struct {
    bit do_load;
    int di;
    int df;
    int exp_baud;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected oversample periods from the fractional-accumulator rule.
  task automatic push_exp(input int di, input int df, input int exp_baud);
    int acc, s, p;
    acc = 0;
    for (int k = 0; k < 32; k++) begin
      s   = acc + df;
      p   = di + (s >> 4);
      acc = s & 15;
      os_q.push_back(p);
      if (k % 16 == 15) baud_q.push_back(exp_baud);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 8000 && (os_q.size() != 0 || baud_q.size() != 0); i++) step();
    chk("drain_os_q", os_q.size(), 0);
    chk("drain_baud_q", baud_q.size(), 0);
    os_q.delete();
    baud_q.delete();
  endtask

  task automatic wait_tick(input bit want_baud, output int n, output logic pend_before);
    n = 0;
    pend_before = load_pending;
    do begin
      pend_before = load_pending;
      step();
      n++;
    end while (((want_baud ? baud_tick : os_tick) !== 1'b1) && n < 5000);
    if (n >= 5000) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout actual=%0d required=<5000", n);
    end
  endtask

  task automatic load(input int di, input int df);
    div_int  = 16'(di);
    div_frac = 4'(df);
    div_load = 1'b1;
    step();
    div_load = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_os_tick"}, os_tick, 1'b0);
    chk({tag, "_baud_tick"}, baud_tick, 1'b0);
    chk({tag, "_baud_clk"}, baud_clk, 1'b0);
    chk({tag, "_load_pending"}, load_pending, 1'b0);
  endtask

  // Scoreboard monitor: pops expected intervals when ticks appear.
  always begin
    int exp;
    @(posedge clk);
    #2;
    cyc = cyc + 1;
    if (arm) begin
      arm       = 1'b0;
      cyc       = -1;
      last_os   = 0;
      last_baud = 0;
      tcount    = 0;
    end else if (sb_on) begin
      if (os_tick === 1'b1) begin
        tcount++;
        if (os_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_os_tick actual=cycle %0d required=none", cyc);
        end else begin
          exp = os_q.pop_front();
          chk("os_period", cyc - last_os, exp);
        end
        last_os = cyc;
        chk("baud_clk_level", baud_clk, ((tcount % 16) < 8) ? 1 : 0);
      end
      if (baud_tick === 1'b1) begin
        chk("baud_with_os", os_tick, 1'b1);
        if (baud_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_baud_tick actual=cycle %0d required=none", cyc);
        end else begin
          exp = baud_q.pop_front();
          chk("baud_period", cyc - last_baud, exp);
        end
        last_baud = cyc;
      end
    end
  end

  initial begin
    #(54.254 * 60000.0);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int   n;
    logic pb;

    vecs[0] = '{1'b0, 10, 0, 160};
    vecs[1] = '{1'b1, 120, 0, 1920};
    vecs[2] = '{1'b1, 10, 8, 168};
    vecs[3] = '{1'b1, 2, 0, 32};
    vecs[4] = '{1'b1, 7, 4, 116};

    rst = 1'b0; en = 1'b0; div_int = 16'd0; div_frac = 4'd0; div_load = 1'b0;
    repeat (3) step();
    chk_idle_outputs("reset");
    chk("reset_cfg_err", cfg_err, 1'b0);
    rst = 1'b1;
    step();

    // Table-driven divisor runs
    foreach (vecs[v]) begin
      if (vecs[v].do_load) begin
        div_int  = 16'(vecs[v].di);
        div_frac = 4'(vecs[v].df);
        div_load = 1'b1;
        step();
        div_load = 1'b0;
        chk("vec_pending_set", load_pending, 1'b1);
        step();
        chk("vec_pending_idle_apply", load_pending, 1'b0);
      end
      push_exp(vecs[v].di, vecs[v].df, vecs[v].exp_baud);
      en = 1'b1; arm = 1'b1; sb_on = 1'b1;
      wait_drain();
      en = 1'b0;
      step();
      sb_on = 1'b0;
      chk_idle_outputs("vec_disabled");
    end

    // Rejected divisor: timing unchanged, sticky flag, cleared by a good load
    load(10, 0);
    step();
    push_exp(10, 0, 160);
    en = 1'b1; arm = 1'b1; sb_on = 1'b1;
    repeat (25) step();
    load(1, 0);
    chk("cfg_err_set", cfg_err, 1'b1);
    chk("cfg_err_no_pending", load_pending, 1'b0);
    repeat (3) step();
    chk("cfg_err_sticky", cfg_err, 1'b1);
    wait_drain();
    load(20, 0);
    chk("cfg_err_cleared", cfg_err, 1'b0);
    chk("cfg_good_pending", load_pending, 1'b1);
    en = 1'b0;
    step();
    sb_on = 1'b0;
    chk("cfg_idle_apply", load_pending, 1'b0);

    // Live load of 120 applied only at the next bit boundary
    load(10, 0);
    step();
    en = 1'b1;
    wait_tick(1'b1, n, pb);
    step();
    step();
    load(120, 0);
    chk("live_pending_set", load_pending, 1'b1);
    wait_tick(1'b1, n, pb);
    chk("live_old_baud_gap", n + 3, 160);
    chk("live_pending_before_baud", pb, 1'b1);
    chk("live_pending_after_baud", load_pending, 1'b0);
    wait_tick(1'b0, n, pb);
    chk("live_os_120", n, 120);
    wait_tick(1'b1, n, pb);
    chk("live_baud_1920", n + 120, 1920);

    // Reset mid-period discards pending state and restores the default
    load(40, 0);
    chk("rst_pending_before", load_pending, 1'b1);
    repeat (50) step();
    rst = 1'b0;
    step();
    chk_idle_outputs("midrst");
    chk("midrst_cfg_err", cfg_err, 1'b0);
    rst = 1'b1; arm = 1'b1; sb_on = 1'b1;
    push_exp(10, 0, 160);
    wait_drain();
    en = 1'b0;
    step();
    sb_on = 1'b0;

    // div_load on a baud_tick edge: old shadow now, new one a bit later
    en = 1'b1;
    wait_tick(1'b1, n, pb);
    load(20, 0);
    chk("coinc_pending_a", load_pending, 1'b1);
    repeat (158) step();
    div_int = 16'd30; div_frac = 4'd0; div_load = 1'b1;
    step();
    div_load = 1'b0;
    chk("coinc_baud_tick", baud_tick, 1'b1);
    chk("coinc_pending_kept", load_pending, 1'b1);
    wait_tick(1'b0, n, pb);
    chk("coinc_os_20", n, 20);
    wait_tick(1'b1, n, pb);
    chk("coinc_baud_320", n + 20, 320);
    chk("coinc_pending_before", pb, 1'b1);
    chk("coinc_pending_after", load_pending, 1'b0);
    wait_tick(1'b0, n, pb);
    chk("coinc_os_30", n, 30);
    en = 1'b0;
    step();
    chk_idle_outputs("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
